// File: rtl/seq_detect_ctrl_if.sv
// Bus between the bit-serial source/controller and the pattern detector.
// Valid/ready: config transfers on an edge where cfg_valid and cfg_ready are both 1; cfg_ready never waits on cfg_valid.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_limit, start, abort, in_valid, in,
    input  cfg_ready, out, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_limit, start, abort, in_valid, in,
    output cfg_ready, out, match_count, busy, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with overlapping match, saturating
// match counter and an optional match limit that parks the block in DONE.
module seq_detect_ctrl #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1001
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  seq_detect_ctrl_if.slave   io_bus,
  output logic [1:0]         o_dbg_state
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PAT_W-1:0]   r_pattern;
  logic [CNT_W-1:0]   r_limit;
  logic [PAT_W-2:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_out;
  logic [CNT_W-1:0]   r_count;

  logic [PAT_W-1:0]   w_window;
  logic               w_cfg_ready;
  logic               w_shift;
  logic               w_full;
  logic               w_match;
  logic [CNT_W:0]     w_cnt_plus;
  logic               w_limit_hit;
  logic               w_arm;

  assign w_cfg_ready = (r_state == S_IDLE);
  assign w_window    = {r_hist, io_bus.in};
  // abort outranks everything, so it also suppresses the shift and the match
  assign w_shift     = (r_state == S_RUN) && io_bus.in_valid && !io_bus.abort;
  assign w_full      = (r_fill >= FILL_W'(PAT_W - 1));
  assign w_match     = w_shift && w_full && (w_window == r_pattern);
  assign w_cnt_plus  = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
  assign w_limit_hit = w_match && (r_limit != '0) && (w_cnt_plus == {1'b0, r_limit});
  assign w_arm       = (r_state != S_RUN) && io_bus.start && !io_bus.abort;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_arm) w_next = S_RUN;
      S_RUN: begin
        if (io_bus.abort)     w_next = S_IDLE;
        else if (w_limit_hit) w_next = S_DONE;
      end
      S_DONE: begin
        if (io_bus.abort)     w_next = S_IDLE;
        else if (w_arm)       w_next = S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pattern <= DEFAULT_PAT;
      r_limit   <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_out     <= 1'b0;
      r_count   <= '0;
    end else begin
      // config taken in IDLE lands on the same edge as start, so the run uses it
      if (io_bus.cfg_valid && w_cfg_ready) begin
        r_pattern <= io_bus.cfg_pattern;
        r_limit   <= io_bus.cfg_limit;
      end
      if (w_arm) begin
        r_hist  <= '0;
        r_fill  <= '0;
        r_count <= '0;
        r_out   <= 1'b0;
      end else if (w_shift) begin
        r_hist <= w_window[PAT_W-2:0];
        if (r_fill != FILL_W'(PAT_W)) r_fill <= r_fill + 1'b1;
        r_out <= w_match;
        if (w_match && !w_cnt_plus[CNT_W]) r_count <= w_cnt_plus[CNT_W-1:0];
      end else begin
        r_out <= 1'b0;
      end
    end
  end

  assign io_bus.cfg_ready   = w_cfg_ready;
  assign io_bus.out         = r_out;
  assign io_bus.match_count = r_count;
  assign io_bus.busy        = (r_state == S_RUN);
  assign io_bus.done        = (r_state == S_DONE);
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a vector table of per-cycle stimulus with expected
// outputs, plus hand-written sequences for async reset and pattern revert.
module tb_seq_detect_ctrl;

  typedef struct {
    logic       cv;
    logic [3:0] pat;
    logic [7:0] lim;
    logic       st;
    logic       ab;
    logic       iv;
    logic       din;
    logic       eo;
    logic [7:0] ec;
    logic       eb;
    logic       ed;
    logic       er;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;
  vec_t       vecs[$];
  logic [11:0] exp_q[$];

  seq_detect_ctrl_if #(.PAT_W(4), .CNT_W(8)) bus ();

  seq_detect_ctrl #(.PAT_W(4), .CNT_W(8), .DEFAULT_PAT(4'b1001)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_idle();
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = 4'h0;
    bus.cfg_limit   = 8'd0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in          = 1'b0;
  endtask

  task automatic add(input logic cv, input logic [3:0] pat, input logic [7:0] lim,
                     input logic st, input logic ab, input logic iv, input logic din,
                     input logic eo, input logic [7:0] ec, input logic eb,
                     input logic ed, input logic er);
    vec_t v;
    v = '{cv, pat, lim, st, ab, iv, din, eo, ec, eb, ed, er};
    vecs.push_back(v);
  endtask

  task automatic expect_out(input logic eo, input logic [7:0] ec, input logic eb,
                            input logic ed, input logic er);
    exp_q.push_back({eo, ec, eb, ed, er});
  endtask

  // scoreboard
  task automatic check_out(input string name);
    logic [11:0] e;
    logic [11:0] a;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    a = {bus.out, bus.match_count, bus.busy, bus.done, bus.cfg_ready};
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got out=%0b cnt=%0d busy=%0b done=%0b rdy=%0b want out=%0b cnt=%0d busy=%0b done=%0b rdy=%0b",
               name, a[11], a[10:3], a[2], a[1], a[0], e[11], e[10:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    bus.cfg_valid   = v.cv;
    bus.cfg_pattern = v.pat;
    bus.cfg_limit   = v.lim;
    bus.start       = v.st;
    bus.abort       = v.ab;
    bus.in_valid    = v.iv;
    bus.in          = v.din;
    expect_out(v.eo, v.ec, v.eb, v.ed, v.er);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic step_bit(input logic din, input logic eo, input logic [7:0] ec,
                          input string name);
    vec_t v;
    v = '{1'b0, 4'h0, 8'd0, 1'b0, 1'b0, 1'b1, din, eo, ec, 1'b1, 1'b0, 1'b0};
    apply(v, name);
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    drive_idle();
    rst_n = 1'b0;
    #1;
    expect_out(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check_out("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    //   cv pat    lim    st ab iv in   out cnt   busy done rdy
    // default pattern, single match then overlap
    add(0, 4'h0, 8'd0,  1, 0, 0, 0,   0, 8'd0,  1, 0, 0);  // 0 start
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   1, 8'd1,  1, 0, 0);  // 4 first match
    add(0, 4'h0, 8'd0,  0, 0, 0, 0,   0, 8'd1,  1, 0, 0);  // pulse lasts one cycle
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd1,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd1,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   1, 8'd2,  1, 0, 0);  // 8 overlapping match
    // start in RUN ignored, then gapped input
    add(0, 4'h0, 8'd0,  1, 0, 1, 0,   0, 8'd2,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 0, 1,   0, 8'd2,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd2,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 0, 0,   0, 8'd2,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   1, 8'd3,  1, 0, 0);  // 13 match across gaps
    // abort on the completing bit
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd3,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd3,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 1, 1, 1,   0, 8'd3,  0, 0, 1);  // 16 abort wins
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   0, 8'd3,  0, 0, 1);  // IDLE ignores bits
    // limit of 2, config and start together
    add(1, 4'h9, 8'd2,  1, 0, 0, 0,   0, 8'd0,  1, 0, 0);  // 18
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   1, 8'd1,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd1,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd1,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   1, 8'd2,  0, 1, 0);  // 25 limit reached
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd2,  0, 1, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd2,  0, 1, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   0, 8'd2,  0, 1, 0);  // DONE ignores bits
    add(1, 4'hF, 8'd0,  0, 0, 0, 0,   0, 8'd2,  0, 1, 0);  // cfg refused in DONE
    add(0, 4'h0, 8'd0,  1, 0, 0, 0,   0, 8'd0,  1, 0, 0);  // 30 re-arm
    add(0, 4'h0, 8'd0,  0, 1, 0, 0,   0, 8'd0,  0, 0, 1);
    // pattern 1111, then cfg offered during RUN
    add(1, 4'hF, 8'd0,  0, 0, 0, 0,   0, 8'd0,  0, 0, 1);  // 32
    add(0, 4'h0, 8'd0,  1, 0, 0, 0,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   0, 8'd0,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   1, 8'd1,  1, 0, 0);
    add(0, 4'h0, 8'd0,  0, 0, 1, 1,   1, 8'd2,  1, 0, 0);
    add(1, 4'h0, 8'd1,  0, 0, 1, 1,   1, 8'd3,  1, 0, 0);  // 39 cfg ignored
    add(0, 4'h0, 8'd0,  0, 0, 1, 0,   0, 8'd3,  1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // pattern 1111 still live: history 110 -> bits 1,1,1,1
    step_bit(1'b1, 1'b0, 8'd3, "p1111_a");
    step_bit(1'b1, 1'b0, 8'd3, "p1111_b");
    step_bit(1'b1, 1'b0, 8'd3, "p1111_c");
    step_bit(1'b1, 1'b1, 8'd4, "p1111_d");

    // asynchronous reset in the middle of a cycle
    #3;
    rst_n = 1'b0;
    drive_idle();
    #1;
    expect_out(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check_out("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    v = '{1'b0, 4'h0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    apply(v, "rearm_after_reset");
    step_bit(1'b1, 1'b0, 8'd0, "post_reset_bit1");
    // four ones would match 1111; default pattern must be back
    step_bit(1'b1, 1'b0, 8'd0, "default_pat_b");
    step_bit(1'b1, 1'b0, 8'd0, "default_pat_c");
    step_bit(1'b1, 1'b0, 8'd0, "default_pat_d");
    step_bit(1'b0, 1'b0, 8'd0, "default_pat_e");
    step_bit(1'b0, 1'b0, 8'd0, "default_pat_f");
    step_bit(1'b1, 1'b1, 8'd1, "default_pat_match");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
